led_framebuffer: RTL
====================

// Module: led_framebuffer
// PURPOSE
// - Double-buffered grayscale frame store feeding pixeldriver; sits directly upstream of it.
// - Host side writes a frame into the back bank; pixeldriver reads pixels from the front bank.
// - Bank swap is deferred to pixeldriver's frame boundary, so a displayed frame never tears.
// - Optional hardware clear zero-fills the back bank.
// PARAMETERS
// - PIXELS   192  pixels per frame: 12 serial lines (6 left + 6 right) x 16 channels.
// - GS_BITS  12   grayscale bits per pixel; matches the driver's grayscale word.
// - AW       8    pixel address width; must satisfy 2**AW >= PIXELS.
// PORTS
// - clock         in   1        system clock; the only clock.
// - reset_n       in   1        synchronous, active-low reset.
// - wr_en         in   1        host write strobe; back bank only.
// - wr_addr       in   AW       host pixel address.
// - wr_data       in   GS_BITS  host pixel value.
// - wr_ready      out  1        high when host writes are accepted.
// - clear_req     in   1        pulse: zero-fill the back bank.
// - swap_req      in   1        pulse: request a front/back swap.
// - swap_pending  out  1        swap requested, not yet committed.
// - swap_done     out  1        1-cycle pulse on the cycle the swap commits.
// - front_bank    out  1        index of the bank currently displayed.
// - frame_start   in   1        1-cycle pulse from pixeldriver at each frame boundary.
// - rd_en         in   1        pixeldriver read strobe.
// - rd_addr       in   AW       pixeldriver pixel address.
// - rd_data       out  GS_BITS  front-bank pixel value.
// - rd_valid      out  1        rd_data valid; asserted 1 cycle after rd_en.
// BEHAVIOUR
// - Reset (reset_n=0 at a clock edge) gives these values:
//   - front_bank=0, swap_pending=0, swap_done=0, rd_valid=0, rd_data=0, wr_ready=1.
//   - The FSM goes to IDLE.
//   - RAM contents are not reset; reads after reset are undefined until written.
// - Reset mid-clear aborts the clear at once; the partially cleared bank keeps its data.
// - Reads: rd_en at cycle N gives rd_valid=1 and rd_data=front[rd_addr] at N+1.
//   - When rd_en=0, rd_valid=0 and rd_data holds its last value.
//   - If rd_addr >= PIXELS, rd_data=0 and rd_valid=1.
// - Reads are never stalled, including during a clear, a swap or a host write.
// - Writes: wr_en && wr_ready stores wr_data at back[wr_addr].
//   - If wr_addr >= PIXELS, the write is dropped silently.
//   - A write while wr_ready=0 is dropped; there is no buffering.
// - FSM states: IDLE, CLEAR.
//   - IDLE -> CLEAR on clear_req; a clear counter starts at 0.
//   - CLEAR writes 0 to back[cnt] on each cycle, cnt=0..PIXELS-1, then returns to IDLE.
//   - A clear takes exactly PIXELS cycles; wr_ready=0 throughout CLEAR.
//   - clear_req during CLEAR is ignored.
// - Swap flag:
//   - swap_req sets swap_pending on the next cycle.
//   - Further swap_req pulses while pending merge into it and are not counted.
//   - Commit condition: frame_start && (swap_pending || swap_req) && state==IDLE.
//   - On commit: front_bank toggles, swap_pending clears, swap_done pulses for 1 cycle.
//   - A swap_req on the same cycle as frame_start commits on that frame_start.
//   - During CLEAR the swap stays pending; it commits on the first frame_start after CLEAR ends.
// - Simultaneous events:
//   - Host write on the commit cycle goes to the pre-swap back bank, i.e. the new front bank.
//   - Read on the commit cycle returns the pre-swap front bank.
//   - From the next cycle, reads use the new front bank.
// STRUCTURE
// - Package led_pkg holds:
//   - constants LED_GS_BITS=12, LED_LINES=6, LED_CHANNELS=16, LED_PIXELS;
//   - localparam function for AW;
//   - FSM state encoding fb_state_t (IDLE, CLEAR).
// - Sub-module led_fb_ram: simple dual-port RAM, depth 2*PIXELS, one write port, one registered read port.
//   - Bank select is the address MSB.
//   - Write address is {~front_bank, addr}; read address is {front_bank, addr}.
//   - Must infer block RAM.
// - Top level holds the FSM, clear counter, swap flag, address range checks and wr_ready mux.
// TESTING
// 1. Reset, then write back[5]=0xABC, swap_req, frame_start.
//    -> swap_done pulse; front_bank=1; rd_en addr 5 gives rd_data=0xABC, rd_valid=1 one cycle later.
// 2. swap_req with no frame_start for 100 cycles.
//    -> swap_pending=1 throughout, front_bank unchanged; first frame_start commits.
// 3. swap_req and frame_start on the same cycle.
//    -> commit on that cycle; swap_done asserts the next cycle; no pending state left.
// 4. clear_req, then swap_req and frame_start during the clear.
//    -> wr_ready=0 for exactly 192 cycles; no commit during CLEAR.
//    -> commit on the next frame_start; all 192 new-front reads return 0.
// 5. Write with wr_addr=200, then read rd_addr=200.
//    -> no RAM change; rd_data=0, rd_valid=1.
// 6. reset_n=0 at clear cycle 50.
//    -> IDLE, wr_ready=1, front_bank=0, swap_pending=0; the bank keeps entries 50..191.

Source files
------------

// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : shared constants, address-width helper and FSM encoding for the
//           LED frame buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int LED_GS_BITS  = 12;
    localparam int LED_LINES    = 6;
    localparam int LED_CHANNELS = 16;
    // Left and right halves each drive LED_LINES serial lines.
    localparam int LED_PIXELS   = 2 * LED_LINES * LED_CHANNELS;

    function automatic int led_addr_width(input int pixels);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= pixels) return w;
        end
        return 32;
    endfunction

    localparam int LED_AW = led_addr_width(LED_PIXELS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

`default_nettype wire

// File: rtl/led_fb_ram.sv
// ============================================================================
// led_fb_ram : simple dual-port RAM, one write port and one registered read
//              port; the address MSB selects the bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_fb_ram #(
    parameter int DW = 12,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Bank bit on top of the pixel address: two banks of 2**(AW-1) words.
    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/led_framebuffer.sv
// ============================================================================
// led_framebuffer : double-buffered grayscale frame store with deferred,
//                   tear-free bank swap and hardware back-bank clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_framebuffer
    import led_pkg::*;
#(
    parameter int PIXELS  = LED_PIXELS,
    parameter int GS_BITS = LED_GS_BITS,
    parameter int AW      = led_addr_width(LED_PIXELS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [GS_BITS-1:0] wr_data,
    output logic               wr_ready,
    input  logic               clear_req,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               front_bank,
    input  logic               frame_start,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [GS_BITS-1:0] rd_data,
    output logic               rd_valid
);

    localparam logic [AW:0]   c_PIX  = (AW+1)'(PIXELS);
    localparam logic [AW-1:0] c_LAST = AW'(PIXELS - 1);

    fb_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic         r_front;
    logic         r_pending;
    logic         r_done;
    logic         r_valid;
    logic         r_rd_zero;
    logic         r_wr_ready;

    logic               w_wr_in;
    logic               w_rd_in;
    logic               w_host_we;
    logic               w_clr_we;
    logic               w_ram_we;
    logic               w_ram_re;
    logic               w_commit;
    logic [AW:0]        w_ram_waddr;
    logic [AW:0]        w_ram_raddr;
    logic [GS_BITS-1:0] w_ram_wdata;
    logic [GS_BITS-1:0] w_ram_q;

    assign w_wr_in   = ({1'b0, wr_addr} < c_PIX);
    assign w_rd_in   = ({1'b0, rd_addr} < c_PIX);
    assign w_host_we = wr_en && r_wr_ready && w_wr_in;
    assign w_clr_we  = (r_state == CLEAR);
    // Gating with reset_n makes a reset mid-clear stop before touching the next entry.
    assign w_ram_we    = reset_n && (w_host_we || w_clr_we);
    assign w_ram_waddr = {~r_front, (w_clr_we ? r_cnt : wr_addr)};
    assign w_ram_wdata = w_clr_we ? '0 : wr_data;
    assign w_ram_re    = reset_n && rd_en && w_rd_in;
    assign w_ram_raddr = {r_front, rd_addr};
    assign w_commit    = frame_start && (r_pending || swap_req) && (r_state == IDLE);

    led_fb_ram #(
        .DW (GS_BITS),
        .AW (AW + 1)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_front    <= 1'b0;
            r_pending  <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_wr_ready <= 1'b1;
        end else begin
            r_done  <= w_commit;
            r_valid <= rd_en;
            if (rd_en) r_rd_zero <= !w_rd_in;

            if (w_commit) begin
                r_front   <= ~r_front;
                r_pending <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state    <= CLEAR;
                        r_cnt      <= '0;
                        r_wr_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state    <= IDLE;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range reads and the post-reset state both present zero, masking the unreset RAM.
    assign rd_data      = r_rd_zero ? '0 : w_ram_q;
    assign rd_valid     = r_valid;
    assign wr_ready     = r_wr_ready;
    assign swap_pending = r_pending;
    assign swap_done    = r_done;
    assign front_bank   = r_front;

endmodule

`default_nettype wire
